// File: rtl/motor_qbus.sv
// motor_qbus: bus-mapped multi-axis step generator with a segment queue per channel.
// Optional build macro: MOTOR_QBUS_COORD_EN adds signed 32-bit position counters at 0xC0+4k.
// Bus protocol: a write is accepted on any clock edge where write is high, the address hits
// and the relevant byte enable is set (no back-pressure); a read returns data on rddata one
// clock after rdaddr is presented, with no valid/ready handshake.
// Step timing: the LOAD cycle is the first cycle run[k] is high; pulses appear on step[k]
// P+1, 2P+1, ... cycles after that cycle, where P = max(T,2).
module motor_qbus #(
  parameter int          MOTORS = 4,
  parameter int          DEPTH  = 16,
  parameter logic [15:0] BAR    = 16'h0000,
  parameter logic [15:0] MASK   = 16'h00FF
) (
  input  logic                clk,
  input  logic                sclr,
  input  logic [15:0]         rdaddr,
  input  logic [15:0]         wraddr,
  input  logic [1:0]          be,
  input  logic                write,
  input  logic [15:0]         wrdata,
  output logic [15:0]         rddata,
  input  logic                permit,
  input  logic                cstop,
  output logic [MOTORS-1:0]   step,
  output logic [MOTORS-1:0]   dir,
  output logic [MOTORS-1:0]   run,
  output logic                any_run,
  output logic [2*MOTORS-1:0] dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  // Byte-lane merge used by every writable register.
  function automatic logic [15:0] merge16(input logic [15:0] old_v, input logic [15:0] new_v,
                                          input logic [15:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction

  // Bus side
  logic        wr_hit, rd_hit, abort;
  logic [15:0] wr_loc, rd_loc, bmask, wr_eff, rd_val, rddata_q;

  // Control registers
  logic [31:0]       stage_n_q [MOTORS];
  logic [31:0]       stage_t_q [MOTORS];
  logic              oe_q;
  logic [MOTORS-1:0] main_dir_q, ovf_q;

  // Queues
  logic [63:0]       mem_q [MOTORS][DEPTH];
  logic [63:0]       head  [MOTORS];
  logic [AW-1:0]     wp_q  [MOTORS];
  logic [AW-1:0]     rp_q  [MOTORS];
  logic [CW-1:0]     cnt_q [MOTORS];
  logic [MOTORS-1:0] push_req, push_ok, pop, full, empty, ovf_set, ovf_clr;

  // Channel engines
  state_t            state_q [MOTORS];
  state_t            state_d [MOTORS];
  logic [31:0]       seg_n_q [MOTORS];
  logic [31:0]       seg_t_q [MOTORS];
  logic [31:0]       rem_q   [MOTORS];
  logic [31:0]       rem_d   [MOTORS];
  logic [31:0]       per_q   [MOTORS];
  logic [31:0]       per_d   [MOTORS];
  logic [31:0]       ctr_q   [MOTORS];
  logic [31:0]       ctr_d   [MOTORS];
  logic [MOTORS-1:0] fire, step_q, dir_q;

  assign wr_hit = write && ((wraddr & ~MASK) == BAR);
  assign rd_hit = ((rdaddr & ~MASK) == BAR);
  assign wr_loc = wraddr & MASK;
  assign rd_loc = rdaddr & MASK;
  assign bmask  = {{8{be[1]}}, {8{be[0]}}};
  assign wr_eff = wrdata & bmask;

  // Abort from the bus strobe or the emergency stop input; it overrides push and pop.
  assign abort = cstop || (wr_hit && (wr_loc == 16'h0082) && wr_eff[1]);

  // Queue status and per-channel push/pop strobes; full is judged before any same-cycle pop.
  always_comb begin
    for (int k = 0; k < MOTORS; k++) begin
      full[k]     = (cnt_q[k] == CW'(DEPTH));
      empty[k]    = (cnt_q[k] == '0);
      push_req[k] = wr_hit && (wr_loc == 16'h0080) && wr_eff[k];
      push_ok[k]  = push_req[k] && !full[k] && !abort;
      ovf_set[k]  = push_req[k] && full[k] && !abort;
      ovf_clr[k]  = wr_hit && (wr_loc == 16'h0088) && wr_eff[8+k];
      pop[k]      = (state_q[k] == S_IDLE) && !empty[k] && permit && oe_q && !abort;
      head[k]     = mem_q[k][rp_q[k]];
    end
  end

  // Staging registers, output enable, main direction and overflow flags.
  always_ff @(posedge clk) begin
    if (sclr) begin
      for (int k = 0; k < MOTORS; k++) begin
        stage_n_q[k] <= '0;
        stage_t_q[k] <= '1;
      end
      oe_q       <= 1'b0;
      main_dir_q <= '0;
      ovf_q      <= '0;
    end else begin
      for (int k = 0; k < MOTORS; k++) begin
        if (wr_hit && wr_loc == 16'(8*k))
          stage_n_q[k][15:0]  <= merge16(stage_n_q[k][15:0], wrdata, bmask);
        if (wr_hit && wr_loc == 16'(8*k + 2))
          stage_n_q[k][31:16] <= merge16(stage_n_q[k][31:16], wrdata, bmask);
        if (wr_hit && wr_loc == 16'(8*k + 4))
          stage_t_q[k][15:0]  <= merge16(stage_t_q[k][15:0], wrdata, bmask);
        if (wr_hit && wr_loc == 16'(8*k + 6))
          stage_t_q[k][31:16] <= merge16(stage_t_q[k][31:16], wrdata, bmask);
        if (ovf_set[k])      ovf_q[k] <= 1'b1;
        else if (ovf_clr[k]) ovf_q[k] <= 1'b0;
      end
      if (wr_hit && wr_loc == 16'h0082 && be[0]) oe_q       <= wrdata[0];
      if (wr_hit && wr_loc == 16'h0084 && be[0]) main_dir_q <= wrdata[MOTORS-1:0];
    end
  end

  // Queue storage: written on an accepted push, never reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < MOTORS; k++) begin
      if (push_ok[k]) mem_q[k][wp_q[k]] <= {stage_n_q[k], stage_t_q[k]};
    end
  end

  // Queue pointers and fill levels; abort flushes every queue.
  always_ff @(posedge clk) begin
    if (sclr || abort) begin
      for (int k = 0; k < MOTORS; k++) begin
        wp_q[k]  <= '0;
        rp_q[k]  <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < MOTORS; k++) begin
        if (push_ok[k]) wp_q[k] <= wp_q[k] + 1'b1;
        if (pop[k])     rp_q[k] <= rp_q[k] + 1'b1;
        cnt_q[k] <= cnt_q[k] + CW'(push_ok[k]) - CW'(pop[k]);
      end
    end
  end

  // Channel FSM next state: IDLE pops a segment, LOAD sets up counters, RUN paces the steps.
  always_comb begin
    for (int k = 0; k < MOTORS; k++) begin
      state_d[k] = state_q[k];
      rem_d[k]   = rem_q[k];
      per_d[k]   = per_q[k];
      ctr_d[k]   = ctr_q[k];
      fire[k]    = 1'b0;
      unique case (state_q[k])
        S_IDLE: begin
          if (pop[k]) state_d[k] = S_LOAD;
        end
        S_LOAD: begin
          if (seg_n_q[k] == '0) begin
            state_d[k] = S_IDLE;
          end else begin
            rem_d[k]   = seg_n_q[k][31] ? (~seg_n_q[k] + 32'd1) : seg_n_q[k];
            per_d[k]   = (seg_t_q[k] < 32'd2) ? 32'd2 : seg_t_q[k];
            ctr_d[k]   = per_d[k] - 32'd1;
            state_d[k] = S_RUN;
          end
        end
        S_RUN: begin
          if (permit) begin
            if (ctr_q[k] == '0) begin
              fire[k]  = 1'b1;
              rem_d[k] = rem_q[k] - 32'd1;
              ctr_d[k] = per_q[k] - 32'd1;
              if (rem_q[k] == 32'd1) state_d[k] = S_IDLE;
            end else begin
              ctr_d[k] = ctr_q[k] - 32'd1;
            end
          end
        end
        default: state_d[k] = S_IDLE;
      endcase
      if (abort) begin
        state_d[k] = S_IDLE;
        fire[k]    = 1'b0;
      end
    end
  end

  // Channel FSM registers; the popped queue entry is captured for the LOAD cycle.
  always_ff @(posedge clk) begin
    if (sclr) begin
      for (int k = 0; k < MOTORS; k++) begin
        state_q[k] <= S_IDLE;
        seg_n_q[k] <= '0;
        seg_t_q[k] <= '0;
        rem_q[k]   <= '0;
        per_q[k]   <= '0;
        ctr_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < MOTORS; k++) begin
        state_q[k] <= state_d[k];
        rem_q[k]   <= rem_d[k];
        per_q[k]   <= per_d[k];
        ctr_q[k]   <= ctr_d[k];
        if (pop[k]) begin
          seg_n_q[k] <= head[k][63:32];
          seg_t_q[k] <= head[k][31:0];
        end
      end
    end
  end

  // Registered step/dir: steps gated by oe, dir follows main_dir while outputs are disabled.
  always_ff @(posedge clk) begin
    if (sclr) begin
      step_q <= '0;
      dir_q  <= '0;
    end else begin
      step_q <= fire & {MOTORS{oe_q}};
      for (int k = 0; k < MOTORS; k++) begin
        if (!oe_q)
          dir_q[k] <= main_dir_q[k];
        else if (state_q[k] == S_LOAD && seg_n_q[k] != '0)
          dir_q[k] <= seg_n_q[k][31] ^ main_dir_q[k];
      end
    end
  end

`ifdef MOTOR_QBUS_COORD_EN
  logic [31:0] coord_q [MOTORS];

  // Position counters follow emitted steps; a same-cycle bus write to a counter takes priority.
  always_ff @(posedge clk) begin
    if (sclr) begin
      for (int k = 0; k < MOTORS; k++) coord_q[k] <= '0;
    end else begin
      for (int k = 0; k < MOTORS; k++) begin
        if (wr_hit && wr_loc == 16'(16'hC0 + 4*k))
          coord_q[k][15:0]  <= merge16(coord_q[k][15:0], wrdata, bmask);
        else if (wr_hit && wr_loc == 16'(16'hC2 + 4*k))
          coord_q[k][31:16] <= merge16(coord_q[k][31:16], wrdata, bmask);
        else if (fire[k] && oe_q)
          coord_q[k] <= seg_n_q[k][31] ? (coord_q[k] - 32'd1) : (coord_q[k] + 32'd1);
      end
    end
  end
`endif

  // Read mux for the local register map; anything unmapped returns 0.
  always_comb begin
    rd_val = '0;
    if (rd_hit) begin
      case (rd_loc)
        16'h0082: rd_val = {15'd0, oe_q};
        16'h0084: rd_val = 16'(main_dir_q);
        16'h0086: rd_val = {8'(run), 8'(empty)};
        16'h0088: rd_val = {8'(ovf_q), 8'(full)};
        default:  rd_val = '0;
      endcase
      for (int k = 0; k < MOTORS; k++) begin
        if (rd_loc == 16'(8*k))            rd_val = stage_n_q[k][15:0];
        if (rd_loc == 16'(8*k + 2))        rd_val = stage_n_q[k][31:16];
        if (rd_loc == 16'(8*k + 4))        rd_val = stage_t_q[k][15:0];
        if (rd_loc == 16'(8*k + 6))        rd_val = stage_t_q[k][31:16];
        if (rd_loc == 16'(16'hA0 + 2*k))   rd_val = 16'(cnt_q[k]);
`ifdef MOTOR_QBUS_COORD_EN
        if (rd_loc == 16'(16'hC0 + 4*k))   rd_val = coord_q[k][15:0];
        if (rd_loc == 16'(16'hC2 + 4*k))   rd_val = coord_q[k][31:16];
`endif
      end
    end
  end

  // Registered read data, one cycle behind rdaddr.
  always_ff @(posedge clk) begin
    if (sclr) rddata_q <= '0;
    else      rddata_q <= rd_val;
  end

  // Status outputs and FSM state debug view.
  always_comb begin
    dbg_state = '0;
    for (int k = 0; k < MOTORS; k++) begin
      run[k]             = (state_q[k] != S_IDLE);
      dbg_state[2*k +: 2] = state_q[k];
    end
  end

  assign any_run = |run;
  assign step    = step_q;
  assign dir     = dir_q;
  assign rddata  = rddata_q;

endmodule

// File: tb/tb_motor_qbus.sv
// tb_motor_qbus: directed sequence with randomized segment data, checked against a
// segment-level timing model of the step generator.
module tb_motor_qbus;

  localparam int MOTORS = 4;
  localparam int DEPTH  = 16;

  logic                clk = 1'b0;
  logic                sclr = 1'b1;
  logic [15:0]         rdaddr = '0, wraddr = '0, wrdata = '0;
  logic [1:0]          be = 2'b11;
  logic                write = 1'b0, permit = 1'b0, cstop = 1'b0;
  logic [15:0]         rddata;
  logic [MOTORS-1:0]   step, dir, run;
  logic                any_run;
  logic [2*MOTORS-1:0] dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int step_log[$];
  int load_log[$];
  logic [MOTORS-1:0] run_prev = '0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_load_q[$];
  logic [31:0] sb_n[$];
  logic [31:0] sb_t[$];

  motor_qbus #(.MOTORS(MOTORS), .DEPTH(DEPTH), .BAR(16'h0000), .MASK(16'h00FF)) dut (
    .clk(clk), .sclr(sclr), .rdaddr(rdaddr), .wraddr(wraddr), .be(be), .write(write),
    .wrdata(wrdata), .rddata(rddata), .permit(permit), .cstop(cstop), .step(step),
    .dir(dir), .run(run), .any_run(any_run), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Event monitor: records step pulses and run rising edges as (cycle*16 + motor).
  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < MOTORS; k++) begin
      if (step[k]) step_log.push_back(cyc * 16 + k);
      if (run[k] && !run_prev[k]) load_log.push_back(cyc * 16 + k);
    end
    run_prev = run;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] b = 2'b11);
    wraddr = a;
    wrdata = d;
    be     = b;
    write  = 1'b1;
    @(negedge clk);
    write  = 1'b0;
    be     = 2'b11;
  endtask

  task automatic wr32(input logic [15:0] a, input logic [31:0] d);
    bus_wr(a, d[15:0]);
    bus_wr(a + 16'd2, d[31:16]);
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
    rdaddr = a;
    @(negedge clk);
    d = rddata;
  endtask

  task automatic rd_check(input string tag, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic clear_logs();
    step_log.delete();
    load_log.delete();
  endtask

  task automatic wait_run(input int k, input string tag);
    int n = 0;
    while (!run[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, run[k], 1'b1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < budget) begin
      @(negedge clk);
      n++;
      quiet = any_run ? 0 : quiet + 1;
    end
    check(tag, any_run, 1'b0);
  endtask

  // Reference model: segments execute back to back from the first load; a zero segment
  // costs LOAD+IDLE, a non-zero one emits |N| steps spaced max(T,2) apart.
  task automatic model_build(input int load0);
    longint cur, n, mag, p;
    exp_q.delete();
    exp_load_q.delete();
    cur = load0;
    for (int s = 0; s < sb_n.size(); s++) begin
      exp_load_q.push_back(32'(cur));
      n   = longint'($signed(sb_n[s]));
      mag = (n < 0) ? -n : n;
      p   = (sb_t[s] < 2) ? 2 : longint'(sb_t[s]);
      if (mag == 0) begin
        cur = cur + 2;
      end else begin
        for (longint i = 1; i <= mag; i++) exp_q.push_back(32'(cur + 1 + i * p));
        cur = cur + mag * p + 2;
      end
    end
  endtask

  // Scoreboard: compares the observed load/step times of motor k against the model.
  task automatic compare_motor(input int k, input int shift, input string tag);
    int obs_s[$];
    int obs_l[$];
    logic [31:0] e;
    foreach (step_log[i]) if (step_log[i] % 16 == k) obs_s.push_back(step_log[i] / 16);
    foreach (load_log[i]) if (load_log[i] % 16 == k) obs_l.push_back(load_log[i] / 16);
    check({tag, "_loads"}, obs_l.size(), sb_n.size());
    if (obs_l.size() == 0) return;
    model_build(obs_l[0]);
    for (int i = 1; i < exp_load_q.size(); i++)
      check({tag, "_load_time"}, (i < obs_l.size()) ? obs_l[i] : -1, exp_load_q[i]);
    check({tag, "_step_count"}, obs_s.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_step_time"}, (obs_s.size() > 0) ? obs_s.pop_front() : -1, e + 32'(shift));
    end
  endtask

  initial begin
    logic [31:0] n_val, t_val, keep_n, keep_t;
    int tmp;

    // Reset
    repeat (3) @(negedge clk);
    sclr = 1'b0;
    check("rst_step", step, '0);
    check("rst_dir", dir, '0);
    check("rst_run", run, '0);
    check("rst_rddata", rddata, 16'h0000);
    rd_check("rst_stage_n0", 16'h0000, 16'h0000);
    rd_check("rst_stage_t0", 16'h0004, 16'hFFFF);
    rd_check("rst_stage_t3h", 16'h001E, 16'hFFFF);
    rd_check("rst_ctrl", 16'h0082, 16'h0000);
    rd_check("rst_maindir", 16'h0084, 16'h0000);
    rd_check("rst_status", 16'h0086, 16'h000F);
    rd_check("rst_flags", 16'h0088, 16'h0000);
    rd_check("nohit_read", 16'h0104, 16'h0000);

    // Byte enables
    bus_wr(16'h0084, 16'h00FF, 2'b10);
    rd_check("be_maindir", 16'h0084, 16'h0000);
    bus_wr(16'h0000, 16'hABCD, 2'b01);
    rd_check("be_stage", 16'h0000, 16'h00CD);

`ifndef MOTOR_QBUS_COORD_EN
    bus_wr(16'h00C0, 16'h1234);
    rd_check("coord_absent", 16'h00C0, 16'h0000);
`else
    bus_wr(16'h00C0, 16'h1234);
    rd_check("coord_write", 16'h00C0, 16'h1234);
`endif

    // Motor0 N=3, T=10
    permit = 1'b1;
    wr32(16'h0000, 32'd3);
    wr32(16'h0004, 32'd10);
    bus_wr(16'h0080, 16'h0001);
    clear_logs();
    bus_wr(16'h0082, 16'h0001);
    wait_run(0, "s1_start");
    rd_check("s1_status_run", 16'h0086, 16'h010F);
    wait_idle(300, "s1_idle");
    rd_check("s1_status_done", 16'h0086, 16'h000F);
    check("s1_dir", dir[0], 1'b0);
    sb_n = '{32'd3};
    sb_t = '{32'd10};
    compare_motor(0, 0, "s1");

    // Negative N with main_dir set, then cleared
    bus_wr(16'h0084, 16'h0001);
    t_val = $urandom_range(8, 2);
    wr32(16'h0000, 32'hFFFFFFFE);
    wr32(16'h0004, t_val);
    clear_logs();
    bus_wr(16'h0080, 16'h0001);
    wait_idle(300, "s2a_idle");
    check("s2a_dir", dir[0], 1'b0);
    sb_n = '{32'hFFFFFFFE};
    sb_t = '{t_val};
    compare_motor(0, 0, "s2a");
    bus_wr(16'h0084, 16'h0000);
    clear_logs();
    bus_wr(16'h0080, 16'h0001);
    wait_idle(300, "s2b_idle");
    check("s2b_dir", dir[0], 1'b1);
    compare_motor(0, 0, "s2b");

    // Output disable: dir mirrors main_dir
    bus_wr(16'h0082, 16'h0000);
    bus_wr(16'h0084, 16'h0005);
    @(negedge clk);
    check("oe0_dir", dir, 4'h5);
    bus_wr(16'h0084, 16'h0000);
    bus_wr(16'h0082, 16'h0001);

    // Motor1 fill to DEPTH, then overflow
    permit = 1'b0;
    wr32(16'h0008, $urandom_range(9, 1));
    wr32(16'h000C, $urandom_range(30, 3));
    for (int i = 0; i < DEPTH; i++) bus_wr(16'h0080, 16'h0002);
    rd_check("s3_level_full", 16'h00A2, 16'(DEPTH));
    rd_check("s3_flags_full", 16'h0088, 16'h0002);
    bus_wr(16'h0080, 16'h0002);
    rd_check("s3_level_ovf", 16'h00A2, 16'(DEPTH));
    rd_check("s3_flags_ovf", 16'h0088, 16'h0202);
    bus_wr(16'h0088, 16'h0200);
    rd_check("s3_flags_clr", 16'h0088, 16'h0002);
    bus_wr(16'h0082, 16'h0003);
    rd_check("s3_level_abort", 16'h00A2, 16'h0000);
    rd_check("s3_ctrl_kept", 16'h0082, 16'h0001);

    // Motor2 N=3, T=20 with a 7-cycle permit drop before the first step
    permit = 1'b1;
    wr32(16'h0010, 32'd3);
    wr32(16'h0014, 32'd20);
    clear_logs();
    bus_wr(16'h0080, 16'h0004);
    wait_run(2, "s4_start");
    repeat (5) @(negedge clk);
    permit = 1'b0;
    repeat (7) @(negedge clk);
    permit = 1'b1;
    wait_idle(300, "s4_idle");
    sb_n = '{32'd3};
    sb_t = '{32'd20};
    compare_motor(2, 7, "s4");

    // Three segments on every motor, then abort
    permit = 1'b0;
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < MOTORS; k++) begin
        n_val = $urandom_range(3, 1);
        t_val = $urandom_range(10, 3);
        wr32(16'(8 * k), n_val);
        wr32(16'(8 * k + 4), t_val);
        if (k == 3) begin
          keep_n = n_val;
          keep_t = t_val;
        end
      end
      bus_wr(16'h0080, 16'h000F);
    end
    rd_check("s5_level3", 16'h00A6, 16'h0003);
    permit = 1'b1;
    repeat (4) @(negedge clk);
    check("s5_running", run, 4'hF);
    bus_wr(16'h0082, 16'h0003);
    check("s5_abort_run", run, 4'h0);
    check("s5_abort_step", step, 4'h0);
    rd_check("s5_abort_status", 16'h0086, 16'h000F);
    clear_logs();
    repeat (40) @(negedge clk);
    check("s5_no_steps", step_log.size(), 0);
    rd_check("s5_stage_n3", 16'h0018, keep_n[15:0]);
    rd_check("s5_stage_t3", 16'h001C, keep_t[15:0]);
    rd_check("s5_oe_kept", 16'h0082, 16'h0001);

    // Zero segment, then N=1 T=2, then N=2 T=0 (period clamps to 2)
    permit = 1'b0;
    t_val = $urandom_range(50, 0);
    wr32(16'h0000, 32'd0);
    wr32(16'h0004, t_val);
    bus_wr(16'h0080, 16'h0001);
    wr32(16'h0000, 32'd1);
    wr32(16'h0004, 32'd2);
    bus_wr(16'h0080, 16'h0001);
    wr32(16'h0000, 32'd2);
    wr32(16'h0004, 32'd0);
    bus_wr(16'h0080, 16'h0001);
    rd_check("s6_level", 16'h00A0, 16'h0003);
    clear_logs();
    permit = 1'b1;
    wait_run(0, "s6_start");
    wait_idle(300, "s6_idle");
    sb_n = '{32'd0, 32'd1, 32'd2};
    sb_t = '{t_val, 32'd2, 32'd0};
    compare_motor(0, 0, "s6");

    // cstop behaves as abort
    wr32(16'h0000, 32'd4);
    wr32(16'h0004, 32'd5);
    bus_wr(16'h0080, 16'h0001);
    bus_wr(16'h0080, 16'h0001);
    wait_run(0, "cstop_start");
    cstop = 1'b1;
    @(negedge clk);
    cstop = 1'b0;
    check("cstop_run", run, 4'h0);
    rd_check("cstop_level", 16'h00A0, 16'h0000);

    // Reset in the middle of a negative move
    wr32(16'h0008, 32'hFFFFFFFB);
    wr32(16'h000C, 32'd4);
    bus_wr(16'h0080, 16'h0002);
    wait_run(1, "mrst_start");
    repeat (3) @(negedge clk);
    check("mrst_dir_before", dir[1], 1'b1);
    rdaddr = 16'h0082;
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    check("mrst_run", run, 4'h0);
    check("mrst_step", step, 4'h0);
    check("mrst_dir", dir, 4'h0);
    check("mrst_rddata", rddata, 16'h0000);
    clear_logs();
    repeat (30) @(negedge clk);
    tmp = step_log.size();
    check("mrst_no_steps", tmp, 0);
    rd_check("mrst_oe", 16'h0082, 16'h0000);
    rd_check("mrst_stage_t1", 16'h000C, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
